id_ex_fwd_stage: RTL and testbench

- ID/EX pipeline register for the five-stage core.
- Captures decoded operands and control, and detects load-use hazards.
- Precomputes registered forwarding selects one cycle ahead, so the EX-stage 32-bit 3:1 operand muxes get a select straight from a flop with no compare logic in EX.
- Sits between decode and the EX operand muxes; its hazard output stalls IF/ID.

---
 rtl/id_ex_fwd_stage_pkg.sv | 42 ++++
 rtl/id_ex_fwd_stage_if.sv | 52 +++++
 rtl/id_ex_fwd_stage_fwd_sel_calc.sv | 27 ++
 rtl/id_ex_fwd_stage.sv | 88 ++++++++
 tb/tb_id_ex_fwd_stage.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_fwd_stage_pkg.sv
// Shared pipeline definitions for the ID/EX stage: widths, forwarding-select
// encoding and the layout of the opaque control bundle.
package id_ex_fwd_stage_pkg;

    localparam int unsigned DW = 32;
    localparam int unsigned AW = 5;
    localparam int unsigned CW = 12;

    typedef logic [1:0] fwd_sel_t;

    // Encoding is fixed by the EX operand mux wiring
    localparam fwd_sel_t FWD_RF    = 2'b00;
    localparam fwd_sel_t FWD_EXMEM = 2'b01;
    localparam fwd_sel_t FWD_MEMWB = 2'b10;

    localparam logic [AW-1:0] REG_ZERO = '0;

    localparam int unsigned CTRL_ALU_OP_LSB = 0;
    localparam int unsigned CTRL_ALU_OP_W   = 4;
    localparam int unsigned CTRL_ALU_SRC    = 4;
    localparam int unsigned CTRL_MEM_WRITE  = 5;
    localparam int unsigned CTRL_BRANCH     = 6;
    localparam int unsigned CTRL_WB_SEL_LSB = 7;
    localparam int unsigned CTRL_WB_SEL_W   = 2;
    localparam int unsigned CTRL_RSVD_LSB   = 9;

    typedef struct packed {
        logic           valid;
        logic           reg_write;
        logic           mem_read;
        logic [AW-1:0]  rs;
        logic [AW-1:0]  rt;
        logic [AW-1:0]  dest;
        logic [DW-1:0]  rs_data;
        logic [DW-1:0]  rt_data;
        logic [DW-1:0]  imm;
        logic [CW-1:0]  ctrl;
        fwd_sel_t       fwd_a_sel;
        fwd_sel_t       fwd_b_sel;
    } stage_t;

endpackage

// File: rtl/id_ex_fwd_stage_if.sv
// Decode-side inputs, EX/MEM hazard view and EX-side outputs of the ID/EX stage.
interface id_ex_fwd_stage_if;
    import id_ex_fwd_stage_pkg::*;

    logic           freeze;
    logic           flush;
    logic           id_valid;
    logic [AW-1:0]  id_rs;
    logic [AW-1:0]  id_rt;
    logic [AW-1:0]  id_dest;
    logic           id_reg_write;
    logic           id_mem_read;
    logic [DW-1:0]  id_rs_data;
    logic [DW-1:0]  id_rt_data;
    logic [DW-1:0]  id_imm;
    logic [CW-1:0]  id_ctrl;
    logic [AW-1:0]  mem_dest;
    logic           mem_reg_write;

    logic           ex_valid;
    logic           ex_reg_write;
    logic           ex_mem_read;
    logic [AW-1:0]  ex_rs;
    logic [AW-1:0]  ex_rt;
    logic [AW-1:0]  ex_dest;
    logic [DW-1:0]  ex_rs_data;
    logic [DW-1:0]  ex_rt_data;
    logic [DW-1:0]  ex_imm;
    logic [CW-1:0]  ex_ctrl;
    logic [1:0]     ex_fwd_a_sel;
    logic [1:0]     ex_fwd_b_sel;
    logic           load_use_stall;

    modport master (
        output freeze, flush, id_valid, id_rs, id_rt, id_dest, id_reg_write,
               id_mem_read, id_rs_data, id_rt_data, id_imm, id_ctrl,
               mem_dest, mem_reg_write,
        input  ex_valid, ex_reg_write, ex_mem_read, ex_rs, ex_rt, ex_dest,
               ex_rs_data, ex_rt_data, ex_imm, ex_ctrl, ex_fwd_a_sel,
               ex_fwd_b_sel, load_use_stall
    );

    modport slave (
        input  freeze, flush, id_valid, id_rs, id_rt, id_dest, id_reg_write,
               id_mem_read, id_rs_data, id_rt_data, id_imm, id_ctrl,
               mem_dest, mem_reg_write,
        output ex_valid, ex_reg_write, ex_mem_read, ex_rs, ex_rt, ex_dest,
               ex_rs_data, ex_rt_data, ex_imm, ex_ctrl, ex_fwd_a_sel,
               ex_fwd_b_sel, load_use_stall
    );

endinterface

// File: rtl/id_ex_fwd_stage_fwd_sel_calc.sv
// Forwarding select for one source register, computed one cycle ahead of EX.
module id_ex_fwd_stage_fwd_sel_calc
    import id_ex_fwd_stage_pkg::*;
(
    input  logic           src_valid,
    input  logic [AW-1:0]  src,
    input  logic           ex_valid,
    input  logic           ex_reg_write,
    input  logic [AW-1:0]  ex_dest,
    input  logic           mem_reg_write,
    input  logic [AW-1:0]  mem_dest,
    output fwd_sel_t       sel_c
);

    // Stage occupant moves to EX/MEM next cycle, so it is the youngest producer
    always_comb begin
        sel_c = FWD_RF;
        if (src_valid) begin
            if (ex_valid && ex_reg_write && (ex_dest != REG_ZERO) && (ex_dest == src)) begin
                sel_c = FWD_EXMEM;
            end else if (mem_reg_write && (mem_dest != REG_ZERO) && (mem_dest == src)) begin
                sel_c = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/id_ex_fwd_stage.sv
// ID/EX pipeline register with load-use detection and registered forwarding
// selects for the EX operand muxes.
module id_ex_fwd_stage
    import id_ex_fwd_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    id_ex_fwd_stage_if.slave bus
);

    stage_t   stage_q;
    stage_t   stage_d;
    fwd_sel_t fwd_a_c;
    fwd_sel_t fwd_b_c;
    logic     stall_c;

    id_ex_fwd_stage_fwd_sel_calc u_fwd_sel_rs (
        .src_valid     (bus.id_valid),
        .src           (bus.id_rs),
        .ex_valid      (stage_q.valid),
        .ex_reg_write  (stage_q.reg_write),
        .ex_dest       (stage_q.dest),
        .mem_reg_write (bus.mem_reg_write),
        .mem_dest      (bus.mem_dest),
        .sel_c         (fwd_a_c)
    );

    id_ex_fwd_stage_fwd_sel_calc u_fwd_sel_rt (
        .src_valid     (bus.id_valid),
        .src           (bus.id_rt),
        .ex_valid      (stage_q.valid),
        .ex_reg_write  (stage_q.reg_write),
        .ex_dest       (stage_q.dest),
        .mem_reg_write (bus.mem_reg_write),
        .mem_dest      (bus.mem_dest),
        .sel_c         (fwd_b_c)
    );

    // rt is compared even when the instruction does not read it
    always_comb begin
        stall_c = stage_q.valid && stage_q.mem_read && (stage_q.dest != REG_ZERO)
                  && bus.id_valid
                  && ((stage_q.dest == bus.id_rs) || (stage_q.dest == bus.id_rt));
    end

    always_comb begin
        stage_d = stage_q;
        if (bus.flush || stall_c) begin
            stage_d = '0;
        end else begin
            stage_d.valid     = bus.id_valid;
            stage_d.reg_write = bus.id_reg_write;
            stage_d.mem_read  = bus.id_mem_read;
            stage_d.rs        = bus.id_rs;
            stage_d.rt        = bus.id_rt;
            stage_d.dest      = bus.id_dest;
            stage_d.rs_data   = bus.id_rs_data;
            stage_d.rt_data   = bus.id_rt_data;
            stage_d.imm       = bus.id_imm;
            stage_d.ctrl      = bus.id_ctrl;
            stage_d.fwd_a_sel = fwd_a_c;
            stage_d.fwd_b_sel = fwd_b_c;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else if (!bus.freeze) begin
            stage_q <= stage_d;
        end
    end

    assign bus.ex_valid       = stage_q.valid;
    assign bus.ex_reg_write   = stage_q.reg_write;
    assign bus.ex_mem_read    = stage_q.mem_read;
    assign bus.ex_rs          = stage_q.rs;
    assign bus.ex_rt          = stage_q.rt;
    assign bus.ex_dest        = stage_q.dest;
    assign bus.ex_rs_data     = stage_q.rs_data;
    assign bus.ex_rt_data     = stage_q.rt_data;
    assign bus.ex_imm         = stage_q.imm;
    assign bus.ex_ctrl        = stage_q.ctrl;
    assign bus.ex_fwd_a_sel   = stage_q.fwd_a_sel;
    assign bus.ex_fwd_b_sel   = stage_q.fwd_b_sel;
    assign bus.load_use_stall = stall_c;

endmodule

// File: tb/tb_id_ex_fwd_stage.sv
// Directed self-checking bench for the ID/EX forwarding stage.
module tb_id_ex_fwd_stage;
    import id_ex_fwd_stage_pkg::*;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;

    id_ex_fwd_stage_if bus();

    id_ex_fwd_stage dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_id(input logic v, input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic [AW-1:0] dest, input logic rw, input logic mr,
                          input logic [DW-1:0] rsd, input logic [DW-1:0] rtd,
                          input logic [DW-1:0] imm, input logic [CW-1:0] ctrl);
        bus.id_valid     = v;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_dest      = dest;
        bus.id_reg_write = rw;
        bus.id_mem_read  = mr;
        bus.id_rs_data   = rsd;
        bus.id_rt_data   = rtd;
        bus.id_imm       = imm;
        bus.id_ctrl      = ctrl;
    endtask

    task automatic set_mem(input logic [AW-1:0] dest, input logic rw);
        bus.mem_dest      = dest;
        bus.mem_reg_write = rw;
    endtask

    task automatic test_reset();
        bus.freeze = 1'b0;
        bus.flush  = 1'b0;
        set_mem(5'd0, 1'b0);
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h1111_0001, 32'h2222_0002, 32'h0000_0010, 12'h5A5);
        rst_n = 1'b0;
        #3;
        n_checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_ctrl !== 12'h000 || bus.ex_rs_data !== 32'h0) begin
            $display("FAIL reset_initial: got valid=%b ctrl=%h rsd=%h, expected 0/000/0",
                     bus.ex_valid, bus.ex_ctrl, bus.ex_rs_data);
            n_fail++;
        end
        rst_n = 1'b1;
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd3 || bus.ex_reg_write !== 1'b1) begin
            $display("FAIL reset_fill: got valid=%b dest=%0d rw=%b, expected 1/3/1",
                     bus.ex_valid, bus.ex_dest, bus.ex_reg_write);
            n_fail++;
        end
        // Asynchronous assertion away from the clock edge
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_dest !== 5'd0 || bus.ex_reg_write !== 1'b0 ||
            bus.ex_rs_data !== 32'h0 || bus.ex_imm !== 32'h0 || bus.ex_ctrl !== 12'h0 ||
            bus.ex_fwd_a_sel !== 2'b00 || bus.ex_fwd_b_sel !== 2'b00 || bus.load_use_stall !== 1'b0) begin
            $display("FAIL reset_async: got valid=%b dest=%0d ctrl=%h fa=%b fb=%b stall=%b, expected all 0",
                     bus.ex_valid, bus.ex_dest, bus.ex_ctrl, bus.ex_fwd_a_sel, bus.ex_fwd_b_sel,
                     bus.load_use_stall);
            n_fail++;
        end
        #1 rst_n = 1'b1;
        set_id(1'b1, 5'd7, 5'd9, 5'd11, 1'b1, 1'b1, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'hFFFF_FFFC, 12'hABC);
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_rs !== 5'd7 || bus.ex_rt !== 5'd9 || bus.ex_dest !== 5'd11 ||
            bus.ex_reg_write !== 1'b1 || bus.ex_mem_read !== 1'b1 || bus.ex_rs_data !== 32'hDEAD_BEEF ||
            bus.ex_rt_data !== 32'hCAFE_F00D || bus.ex_imm !== 32'hFFFF_FFFC || bus.ex_ctrl !== 12'hABC ||
            bus.ex_fwd_a_sel !== 2'b00 || bus.ex_fwd_b_sel !== 2'b00) begin
            $display("FAIL reset_first_capture: got rs=%0d rt=%0d dest=%0d rsd=%h rtd=%h imm=%h ctrl=%h fa=%b fb=%b",
                     bus.ex_rs, bus.ex_rt, bus.ex_dest, bus.ex_rs_data, bus.ex_rt_data, bus.ex_imm,
                     bus.ex_ctrl, bus.ex_fwd_a_sel, bus.ex_fwd_b_sel);
            n_fail++;
        end
        set_id(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 12'h0);
        tick();
    endtask

    task automatic test_ex_forward();
        set_mem(5'd0, 1'b0);
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h1, 32'h2, 32'h0, 12'h001);
        tick();
        set_id(1'b1, 5'd3, 5'd4, 5'd6, 1'b1, 1'b0, 32'h3, 32'h4, 32'h0, 12'h002);
        tick();
        n_checks++;
        if (bus.ex_fwd_a_sel !== 2'b01 || bus.ex_fwd_b_sel !== 2'b00) begin
            $display("FAIL ex_forward: got fa=%b fb=%b, expected 01/00", bus.ex_fwd_a_sel, bus.ex_fwd_b_sel);
            n_fail++;
        end
        // Same producer seen via rt; rs from the previous instruction (dest 6)
        set_id(1'b1, 5'd6, 5'd6, 5'd8, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 12'h0);
        tick();
        n_checks++;
        if (bus.ex_fwd_a_sel !== 2'b01 || bus.ex_fwd_b_sel !== 2'b01) begin
            $display("FAIL ex_forward_both: got fa=%b fb=%b, expected 01/01", bus.ex_fwd_a_sel, bus.ex_fwd_b_sel);
            n_fail++;
        end
    endtask

    task automatic test_priority();
        set_mem(5'd0, 1'b0);
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 12'h0);
        tick();
        set_mem(5'd5, 1'b1);
        set_id(1'b1, 5'd6, 5'd5, 5'd12, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 12'h0);
        tick();
        n_checks++;
        if (bus.ex_fwd_b_sel !== 2'b01 || bus.ex_fwd_a_sel !== 2'b00) begin
            $display("FAIL priority_ex_wins: got fa=%b fb=%b, expected 00/01", bus.ex_fwd_a_sel, bus.ex_fwd_b_sel);
            n_fail++;
        end
        set_mem(5'd0, 1'b0);
        set_id(1'b1, 5'd1, 5'd2, 5'd5, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 12'h0);
        tick();
        set_mem(5'd5, 1'b1);
        set_id(1'b1, 5'd6, 5'd5, 5'd12, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 12'h0);
        tick();
        n_checks++;
        if (bus.ex_fwd_b_sel !== 2'b10 || bus.ex_fwd_a_sel !== 2'b00) begin
            $display("FAIL priority_mem: got fa=%b fb=%b, expected 00/10", bus.ex_fwd_a_sel, bus.ex_fwd_b_sel);
            n_fail++;
        end
        // MEM/WB match without write enable must not forward
        set_mem(5'd6, 1'b0);
        set_id(1'b1, 5'd6, 5'd13, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 12'h0);
        tick();
        n_checks++;
        if (bus.ex_fwd_a_sel !== 2'b00) begin
            $display("FAIL mem_no_write: got fa=%b, expected 00", bus.ex_fwd_a_sel);
            n_fail++;
        end
        // Invalid ID instruction never gets a forwarding select
        set_mem(5'd9, 1'b1);
        set_id(1'b0, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 12'h0);
        tick();
        n_checks++;
        if (bus.ex_fwd_a_sel !== 2'b00 || bus.ex_fwd_b_sel !== 2'b00 || bus.ex_valid !== 1'b0) begin
            $display("FAIL idle_no_fwd: got fa=%b fb=%b valid=%b, expected 00/00/0",
                     bus.ex_fwd_a_sel, bus.ex_fwd_b_sel, bus.ex_valid);
            n_fail++;
        end
        set_mem(5'd0, 1'b0);
    endtask

    task automatic test_load_use();
        set_mem(5'd0, 1'b0);
        set_id(1'b1, 5'd1, 5'd0, 5'd8, 1'b1, 1'b1, 32'h0, 32'h0, 32'h4, 12'h010);
        tick();
        set_id(1'b1, 5'd8, 5'd9, 5'd10, 1'b1, 1'b0, 32'h88, 32'h99, 32'h0, 12'h020);
        #1;
        n_checks++;
        if (bus.load_use_stall !== 1'b1) begin
            $display("FAIL load_use_detect: got stall=%b, expected 1", bus.load_use_stall);
            n_fail++;
        end
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_fwd_a_sel !== 2'b00 || bus.ex_fwd_b_sel !== 2'b00 ||
            bus.ex_mem_read !== 1'b0 || bus.ex_reg_write !== 1'b0 || bus.ex_dest !== 5'd0 ||
            bus.ex_ctrl !== 12'h0 || bus.load_use_stall !== 1'b0) begin
            $display("FAIL load_use_bubble: got valid=%b fa=%b mr=%b dest=%0d ctrl=%h stall=%b, expected 0/00/0/0/000/0",
                     bus.ex_valid, bus.ex_fwd_a_sel, bus.ex_mem_read, bus.ex_dest, bus.ex_ctrl,
                     bus.load_use_stall);
            n_fail++;
        end
        set_mem(5'd8, 1'b1);
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_fwd_a_sel !== 2'b10 || bus.ex_fwd_b_sel !== 2'b00 ||
            bus.ex_rs !== 5'd8 || bus.ex_dest !== 5'd10 || bus.ex_rs_data !== 32'h88) begin
            $display("FAIL load_use_resume: got valid=%b fa=%b fb=%b rs=%0d dest=%0d rsd=%h, expected 1/10/00/8/10/88",
                     bus.ex_valid, bus.ex_fwd_a_sel, bus.ex_fwd_b_sel, bus.ex_rs, bus.ex_dest, bus.ex_rs_data);
            n_fail++;
        end
        // Conservative rt compare: load dest 12, consumer names it only as rt
        set_mem(5'd0, 1'b0);
        set_id(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 12'h0);
        tick();
        set_id(1'b1, 5'd3, 5'd12, 5'd0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 12'h0);
        #1;
        n_checks++;
        if (bus.load_use_stall !== 1'b1) begin
            $display("FAIL load_use_rt: got stall=%b, expected 1", bus.load_use_stall);
            n_fail++;
        end
        bus.id_valid = 1'b0;
        #1;
        n_checks++;
        if (bus.load_use_stall !== 1'b0) begin
            $display("FAIL load_use_idle: got stall=%b, expected 0", bus.load_use_stall);
            n_fail++;
        end
        tick();
    endtask

    task automatic test_freeze_flush();
        set_mem(5'd0, 1'b0);
        set_id(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 12'h0);
        tick();
        set_id(1'b1, 5'd3, 5'd2, 5'd7, 1'b1, 1'b0, 32'hAAAA_5555, 32'h1234_5678, 32'h0000_0042, 12'h3C3);
        tick();
        bus.freeze = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_id(1'b1, 5'(i + 20), 5'(i + 24), 5'(i + 14), 1'b0, 1'b0, 32'(i), 32'(i + 5),
                   32'(i + 9), 12'(i + 1));
            tick();
            n_checks++;
            if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd7 || bus.ex_rs_data !== 32'hAAAA_5555 ||
                bus.ex_ctrl !== 12'h3C3 || bus.ex_fwd_a_sel !== 2'b01 || bus.ex_rs !== 5'd3) begin
                $display("FAIL freeze_hold_%0d: got valid=%b dest=%0d rsd=%h ctrl=%h fa=%b rs=%0d, expected 1/7/AAAA5555/3C3/01/3",
                         i, bus.ex_valid, bus.ex_dest, bus.ex_rs_data, bus.ex_ctrl, bus.ex_fwd_a_sel, bus.ex_rs);
                n_fail++;
            end
        end
        bus.flush = 1'b1;
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_dest !== 5'd7 || bus.ex_fwd_a_sel !== 2'b01) begin
            $display("FAIL freeze_beats_flush: got valid=%b dest=%0d fa=%b, expected 1/7/01",
                     bus.ex_valid, bus.ex_dest, bus.ex_fwd_a_sel);
            n_fail++;
        end
        bus.freeze = 1'b0;
        set_id(1'b1, 5'd7, 5'd7, 5'd4, 1'b1, 1'b1, 32'h5, 32'h6, 32'h7, 12'hFFF);
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b0 || bus.ex_dest !== 5'd0 || bus.ex_ctrl !== 12'h0 ||
            bus.ex_reg_write !== 1'b0 || bus.ex_mem_read !== 1'b0 ||
            bus.ex_fwd_a_sel !== 2'b00 || bus.ex_fwd_b_sel !== 2'b00) begin
            $display("FAIL flush_bubble: got valid=%b dest=%0d ctrl=%h rw=%b mr=%b fa=%b fb=%b, expected 0/0/000/0/0/00/00",
                     bus.ex_valid, bus.ex_dest, bus.ex_ctrl, bus.ex_reg_write, bus.ex_mem_read,
                     bus.ex_fwd_a_sel, bus.ex_fwd_b_sel);
            n_fail++;
        end
        bus.flush = 1'b0;
    endtask

    task automatic test_zero_reg();
        set_mem(5'd0, 1'b1);
        set_id(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 32'h0, 32'h0, 32'h0, 12'h0);
        tick();
        set_id(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 12'h0);
        #1;
        n_checks++;
        if (bus.load_use_stall !== 1'b0) begin
            $display("FAIL zero_no_stall: got stall=%b, expected 0", bus.load_use_stall);
            n_fail++;
        end
        tick();
        n_checks++;
        if (bus.ex_valid !== 1'b1 || bus.ex_fwd_a_sel !== 2'b00 || bus.ex_fwd_b_sel !== 2'b00) begin
            $display("FAIL zero_no_fwd: got valid=%b fa=%b fb=%b, expected 1/00/00",
                     bus.ex_valid, bus.ex_fwd_a_sel, bus.ex_fwd_b_sel);
            n_fail++;
        end
        set_mem(5'd0, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        test_reset();
        test_ex_forward();
        test_priority();
        test_load_use();
        test_freeze_flush();
        test_zero_reg();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
